cpu86_bpu_ras_ctrl: RTL and testbench

Return-address-stack controller for the cpu86 branch prediction unit. Consumes the decoded branch-class stream from the prefetch/decode stage. On near CALLs it pushes the return address into the BPU LIFO. On near RETs it pops that LIFO and issues a registered return-target prediction to fetch. On a flush from the execution unit it drains the LIFO.

---
 rtl/cpu86_bpu_ras_ctrl_if.sv | 36 +++
 rtl/cpu86_bpu_ras_ctrl.sv | 101 ++++++++++
 tb/tb_cpu86_bpu_ras_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu86_bpu_ras_ctrl_if.sv
// cpu86_bpu_ras_ctrl_if: branch-class stream, prediction stream, LIFO port and stats of the RAS controller.
interface cpu86_bpu_ras_ctrl_if #(
    parameter int DW    = 16,
    parameter int LEN_W = 4
);
    logic             flush;
    logic             br_s_tvalid;
    logic             br_s_tready;
    logic [1:0]       br_s_ttype;
    logic [DW-1:0]    br_s_tip;
    logic [LEN_W-1:0] br_s_tlen;
    logic             pred_m_tvalid;
    logic             pred_m_tready;
    logic             pred_m_ttaken;
    logic [DW-1:0]    pred_m_ttarget;
    logic             ras_push_vld;
    logic [DW-1:0]    ras_push_data;
    logic             ras_pop_vld;
    logic             ras_pop_ack;
    logic [DW-1:0]    ras_pop_data;
    logic [15:0]      stat_hit_cnt;
    logic [15:0]      stat_miss_cnt;
    logic [15:0]      stat_call_cnt;

    modport slave (
        input  flush, br_s_tvalid, br_s_ttype, br_s_tip, br_s_tlen, pred_m_tready, ras_pop_vld, ras_pop_data,
        output br_s_tready, pred_m_tvalid, pred_m_ttaken, pred_m_ttarget, ras_push_vld, ras_push_data,
               ras_pop_ack, stat_hit_cnt, stat_miss_cnt, stat_call_cnt
    );

    modport master (
        output flush, br_s_tvalid, br_s_ttype, br_s_tip, br_s_tlen, pred_m_tready, ras_pop_vld, ras_pop_data,
        input  br_s_tready, pred_m_tvalid, pred_m_ttaken, pred_m_ttarget, ras_push_vld, ras_push_data,
               ras_pop_ack, stat_hit_cnt, stat_miss_cnt, stat_call_cnt
    );
endinterface

// File: rtl/cpu86_bpu_ras_ctrl.sv
// cpu86_bpu_ras_ctrl: return-address-stack controller; pushes on CALL, pops/predicts on RET, drains on flush.
// Optional statistics counters enabled by defining CPU86_BPU_RAS_STATS_EN.
module cpu86_bpu_ras_ctrl #(
    parameter int DW    = 16,
    parameter int LEN_W = 4,
    parameter int DEPTH = 16
) (
    input logic                clk,
    input logic                resetn,
    cpu86_bpu_ras_ctrl_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {RUN, DRAIN} state_t;

    state_t        state;
    logic          pred_vld;
    logic          pred_taken;
    logic [DW-1:0] pred_target;
    logic [CW-1:0] drain_cnt;
    logic          acc;
    logic          is_call;
    logic          is_ret;
    logic          ret_hit;
    logic          cnt_max;
    logic          drain_pop;

    always_comb begin
        bus.br_s_tready    = (state == RUN) & !bus.flush & (!pred_vld | bus.pred_m_tready);
        acc                = bus.br_s_tvalid & bus.br_s_tready;
        is_call            = acc & (bus.br_s_ttype == 2'd1);
        is_ret             = acc & (bus.br_s_ttype == 2'd2);
        ret_hit            = is_ret & bus.ras_pop_vld;
        cnt_max            = drain_cnt == CW'(DEPTH);
        drain_pop          = (state == DRAIN) & !bus.flush & bus.ras_pop_vld & !cnt_max;
        bus.ras_push_vld   = is_call;
        bus.ras_push_data  = is_call ? bus.br_s_tip + DW'(bus.br_s_tlen) : '0;
        bus.ras_pop_ack    = ret_hit | drain_pop;
        bus.pred_m_tvalid  = pred_vld;
        bus.pred_m_ttaken  = pred_taken;
        bus.pred_m_ttarget = pred_target;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= RUN;
            pred_vld    <= 1'b0;
            pred_taken  <= 1'b0;
            pred_target <= '0;
            drain_cnt   <= '0;
        end else begin
            // a flush while already draining restarts the drain rather than leaving it
            if (bus.flush) begin
                state     <= (state == DRAIN || bus.ras_pop_vld) ? DRAIN : RUN;
                drain_cnt <= '0;
            end else if (state == DRAIN) begin
                if (!bus.ras_pop_vld || cnt_max)
                    state <= RUN;
                else
                    drain_cnt <= drain_cnt + 1'b1;
            end
            if (bus.flush)
                pred_vld <= 1'b0;
            else if (acc) begin
                pred_vld    <= 1'b1;
                pred_taken  <= ret_hit;
                pred_target <= ret_hit ? bus.ras_pop_data : '0;
            end else if (bus.pred_m_tready)
                pred_vld <= 1'b0;
        end
    end

`ifdef CPU86_BPU_RAS_STATS_EN
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
    logic [15:0] call_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
            call_cnt <= '0;
        end else begin
            if (ret_hit && hit_cnt != 16'hFFFF)
                hit_cnt <= hit_cnt + 1'b1;
            if (is_ret && !bus.ras_pop_vld && miss_cnt != 16'hFFFF)
                miss_cnt <= miss_cnt + 1'b1;
            if (is_call && call_cnt != 16'hFFFF)
                call_cnt <= call_cnt + 1'b1;
        end
    end

    assign bus.stat_hit_cnt  = hit_cnt;
    assign bus.stat_miss_cnt = miss_cnt;
    assign bus.stat_call_cnt = call_cnt;
`else
    assign bus.stat_hit_cnt  = '0;
    assign bus.stat_miss_cnt = '0;
    assign bus.stat_call_cnt = '0;
`endif
endmodule

// File: tb/tb_cpu86_bpu_ras_ctrl.sv
// tb_cpu86_bpu_ras_ctrl: scoreboard bench for the RAS controller with a behavioural 16-deep LIFO.
module tb_cpu86_bpu_ras_ctrl;
    logic clk = 1'b0;
    logic resetn = 1'b0;

    cpu86_bpu_ras_ctrl_if #(.DW(16), .LEN_W(4)) bus ();

    cpu86_bpu_ras_ctrl #(.DW(16), .LEN_W(4), .DEPTH(16)) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          exp_hit = 0;
    int          exp_miss = 0;
    int          exp_call = 0;
    logic [15:0] lifo[$];
    logic [15:0] ref_stk[$];
    logic [16:0] sb[$];
    logic [16:0] sb_e;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // behavioural LIFO: drops the oldest entry on overflow
    always @(posedge clk) begin
        if (!resetn) begin
            lifo.delete();
        end else begin
            if (bus.ras_push_vld && bus.ras_pop_ack)
                chk("push_pop_excl", 1, 0);
            if (bus.ras_push_vld) begin
                lifo.push_back(bus.ras_push_data);
                if (lifo.size() > 16)
                    void'(lifo.pop_front());
            end else if (bus.ras_pop_ack && lifo.size() > 0)
                void'(lifo.pop_back());
        end
        bus.ras_pop_vld  <= lifo.size() != 0;
        bus.ras_pop_data <= lifo.size() != 0 ? lifo[$] : 16'h0;
    end

    always @(negedge clk) begin
        if (resetn && bus.pred_m_tvalid && bus.pred_m_tready) begin
            if (sb.size() == 0)
                chk("pred_unexpected", 1, 0);
            else begin
                sb_e = sb.pop_front();
                chk("pred_taken", {31'b0, bus.pred_m_ttaken}, {31'b0, sb_e[16]});
                chk("pred_target", {16'b0, bus.pred_m_ttarget}, {16'b0, sb_e[15:0]});
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] t, input logic [15:0] ip, input logic [3:0] len);
        logic        hit;
        logic [15:0] ra;
        bus.br_s_tvalid = 1'b1;
        bus.br_s_ttype  = t;
        bus.br_s_tip    = ip;
        bus.br_s_tlen   = len;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.br_s_tready) break;
        end
        if (!bus.br_s_tready) begin
            chk("accept_timeout", 0, 1);
            bus.br_s_tvalid = 1'b0;
            return;
        end
        if (t == 2'd1) begin
            ra = ip + {12'b0, len};
            chk("push_vld", {31'b0, bus.ras_push_vld}, 1);
            chk("push_data", {16'b0, bus.ras_push_data}, {16'b0, ra});
            chk("call_no_pop", {31'b0, bus.ras_pop_ack}, 0);
            ref_stk.push_back(ra);
            if (ref_stk.size() > 16)
                void'(ref_stk.pop_front());
            sb.push_back(17'h0);
            exp_call++;
        end else if (t == 2'd2) begin
            hit = ref_stk.size() != 0;
            chk("ret_pop_ack", {31'b0, bus.ras_pop_ack}, {31'b0, hit});
            chk("ret_no_push", {31'b0, bus.ras_push_vld}, 0);
            if (hit) begin
                ra = ref_stk.pop_back();
                sb.push_back({1'b1, ra});
                exp_hit++;
            end else begin
                sb.push_back(17'h0);
                exp_miss++;
            end
        end else
            sb.push_back(17'h0);
        @(posedge clk);
        #1;
        bus.br_s_tvalid = 1'b0;
    endtask

    task automatic chk_stats(input string tag);
`ifdef CPU86_BPU_RAS_STATS_EN
        chk({tag, "_hit"}, {16'b0, bus.stat_hit_cnt}, exp_hit);
        chk({tag, "_miss"}, {16'b0, bus.stat_miss_cnt}, exp_miss);
        chk({tag, "_call"}, {16'b0, bus.stat_call_cnt}, exp_call);
`else
        chk({tag, "_hit"}, {16'b0, bus.stat_hit_cnt}, 0);
        chk({tag, "_miss"}, {16'b0, bus.stat_miss_cnt}, 0);
        chk({tag, "_call"}, {16'b0, bus.stat_call_cnt}, 0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int pops;
        int cyc;
        bus.flush         = 1'b0;
        bus.br_s_tvalid   = 1'b0;
        bus.br_s_ttype    = 2'd0;
        bus.br_s_tip      = 16'h0;
        bus.br_s_tlen     = 4'h0;
        bus.pred_m_tready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_pred_vld", {31'b0, bus.pred_m_tvalid}, 0);
        chk("rst_pred_taken", {31'b0, bus.pred_m_ttaken}, 0);
        chk("rst_pred_target", {16'b0, bus.pred_m_ttarget}, 0);
        chk("rst_push", {31'b0, bus.ras_push_vld}, 0);
        chk("rst_pop", {31'b0, bus.ras_pop_ack}, 0);
        chk("rst_tready", {31'b0, bus.br_s_tready}, 1);
        chk_stats("rst_stat");
        @(posedge clk);
        #1 resetn = 1'b1;
        idle(1);

        send(2'd1, 16'h1000, 4'd3);
        send(2'd2, 16'h1010, 4'd1);
        send(2'd2, 16'h1020, 4'd1);
        send(2'd0, 16'h1030, 4'd2);
        send(2'd3, 16'h1040, 4'd2);
        send(2'd1, 16'hFFFE, 4'd5);
        send(2'd2, 16'h0100, 4'd1);
        idle(2);
        chk_stats("basic_stat");

        for (int i = 1; i <= 18; i++)
            send(2'd1, 16'(i * 16'h0100), 4'd1);
        for (int i = 1; i <= 17; i++)
            send(2'd2, 16'h0000, 4'd1);
        idle(2);

        for (int i = 1; i <= 3; i++)
            send(2'd1, 16'(16'h3000 + i * 16'h10), 4'd4);
        idle(2);
        bus.flush = 1'b1;
        @(negedge clk);
        chk("flush_tready", {31'b0, bus.br_s_tready}, 0);
        chk("flush_push", {31'b0, bus.ras_push_vld}, 0);
        chk("flush_pop", {31'b0, bus.ras_pop_ack}, 0);
        @(posedge clk);
        #1 bus.flush = 1'b0;
        ref_stk.delete();
        pops = 0;
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.br_s_tready) break;
            pops += int'(bus.ras_pop_ack);
            cyc++;
        end
        chk("drain_pops", pops, 3);
        chk("drain_tready_low_cycles", cyc, 4);
        idle(1);
        send(2'd2, 16'h4000, 4'd1);
        idle(2);

        send(2'd1, 16'h2000, 4'd2);
        idle(2);
        bus.pred_m_tready = 1'b0;
        send(2'd2, 16'h2100, 4'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("hold_vld", {31'b0, bus.pred_m_tvalid}, 1);
            chk("hold_target", {16'b0, bus.pred_m_ttarget}, 32'h2002);
            chk("hold_tready", {31'b0, bus.br_s_tready}, 0);
            chk("hold_no_pop", {31'b0, bus.ras_pop_ack}, 0);
        end
        @(posedge clk);
        #1 bus.pred_m_tready = 1'b1;
        idle(1);
        send(2'd2, 16'h2200, 4'd1);
        idle(3);
        chk("sb_empty", sb.size(), 0);
        chk("final_pred_vld", {31'b0, bus.pred_m_tvalid}, 0);
        chk_stats("final_stat");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
